// File: rtl/subdiv_pkg.sv
// Shared definitions for the subdivision engine: scheduler states,
// mesh RAM geometry and the RAM-capacity check used after each subdivide pass.
package subdiv_pkg;

    localparam int          ADDR_WIDTH = 9;
    // Fixed-point 1.0 (Q16.16) used by the averaging stage for its weights.
    localparam logic [31:0] Q_ONE      = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB_LAUNCH,
        ST_SUB_WAIT,
        ST_AVG_LAUNCH,
        ST_AVG_WAIT,
        ST_SWAP,
        ST_DONE,
        ST_ERR
    } sched_state_t;

    // True when the next subdivision pass would not fit in a mesh bank:
    // it needs 3*V + 3*F + 2 words against 2**addr_w available.
    function automatic logic mesh_overflow(input logic [31:0] verts,
                                           input logic [31:0] faces,
                                           input int          addr_w);
        logic [35:0] need;
        logic [35:0] cap;
        need = 36'(verts) * 36'd3 + 36'(faces) * 36'd3 + 36'd2;
        cap  = 36'd1 << addr_w;
        return need > cap;
    endfunction

endpackage

// File: rtl/stage_handshake.sv
// Start/busy handshake for one pipeline stage. While go_i is high the stage
// is first launched (start held until busy is seen), then watched until
// busy falls. A per-stage counter flags a stage that never answers.
module stage_handshake #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic go_i,
    input  logic busy_i,
    output logic start_o,
    output logic accept_o,
    output logic done_pulse_o,
    output logic timeout_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // phase_q: 0 while launching, 1 once the stage has reported busy
    logic             phase_q, phase_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Phase, previous busy sample and the wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            busy_q  <= busy_i;
            cnt_q   <= cnt_d;
        end
    end

    // Level-held start, busy edge detection and counter restart on every phase change.
    always_comb begin
        start_o      = go_i & ~phase_q;
        accept_o     = go_i & ~phase_q & busy_i;
        done_pulse_o = go_i & phase_q & busy_q & ~busy_i;
        timeout_o    = go_i & (cnt_q == CNT_LAST);
        phase_d      = phase_q;
        cnt_d        = cnt_q + CNT_W'(1);
        if (!go_i) begin
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (accept_o) begin
            phase_d = 1'b1;
            cnt_d   = '0;
        end
    end

endmodule

// File: rtl/subdiv_scheduler.sv
// Top-level sequencer: runs N rounds of subdivide -> average, ping-ponging
// the two mesh banks and tracking the growing vertex/face counts.
module subdiv_scheduler #(
    parameter int ITER_W         = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int ADDR_WIDTH     = subdiv_pkg::ADDR_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_start_i,
    input  logic [ITER_W-1:0] cmd_iters_i,
    input  logic [31:0]       vertex_count_in_i,
    input  logic [31:0]       face_count_in_i,
    output logic              sub_start_o,
    input  logic              sub_busy_i,
    input  logic [31:0]       sub_vertex_count_i,
    input  logic [31:0]       sub_face_count_i,
    output logic              avg_start_o,
    input  logic              avg_busy_i,
    output logic [31:0]       vertex_count_o,
    output logic [31:0]       face_count_o,
    output logic              bank_sel_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    import subdiv_pkg::*;

    sched_state_t      state_q, state_d;
    logic [ITER_W-1:0] iters_q, iters_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [31:0]       vcount_q, vcount_d;
    logic [31:0]       fcount_q, fcount_d;
    logic              bank_q, bank_d;
    logic              error_q, error_d;

    logic sub_go, sub_start, sub_accept, sub_done, sub_timeout;
    logic avg_go, avg_start, avg_accept, avg_done, avg_timeout;

    assign sub_go = (state_q == ST_SUB_LAUNCH) || (state_q == ST_SUB_WAIT);
    assign avg_go = (state_q == ST_AVG_LAUNCH) || (state_q == ST_AVG_WAIT);

    stage_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_sub_hs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .go_i        (sub_go),
        .busy_i      (sub_busy_i),
        .start_o     (sub_start),
        .accept_o    (sub_accept),
        .done_pulse_o(sub_done),
        .timeout_o   (sub_timeout)
    );

    stage_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_avg_hs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .go_i        (avg_go),
        .busy_i      (avg_busy_i),
        .start_o     (avg_start),
        .accept_o    (avg_accept),
        .done_pulse_o(avg_done),
        .timeout_o   (avg_timeout)
    );

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            iters_q  <= '0;
            iter_q   <= '0;
            vcount_q <= '0;
            fcount_q <= '0;
            bank_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            iters_q  <= iters_d;
            iter_q   <= iter_d;
            vcount_q <= vcount_d;
            fcount_q <= fcount_d;
            bank_q   <= bank_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic; stage completion is checked before timeout so it wins a tie.
    always_comb begin
        state_d  = state_q;
        iters_d  = iters_q;
        iter_d   = iter_q;
        vcount_d = vcount_q;
        fcount_d = fcount_q;
        bank_d   = bank_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    iters_d  = cmd_iters_i;
                    vcount_d = vertex_count_in_i;
                    fcount_d = face_count_in_i;
                    iter_d   = '0;
                    error_d  = 1'b0;
                    bank_d   = 1'b0;
                    state_d  = (cmd_iters_i == '0) ? ST_DONE : ST_SUB_LAUNCH;
                end
            end
            ST_SUB_LAUNCH: begin
                if (sub_accept)       state_d = ST_SUB_WAIT;
                else if (sub_timeout) state_d = ST_ERR;
            end
            ST_SUB_WAIT: begin
                if (sub_done) begin
                    vcount_d = sub_vertex_count_i;
                    fcount_d = sub_face_count_i;
                    if (mesh_overflow(sub_vertex_count_i, sub_face_count_i, ADDR_WIDTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        bank_d  = ~bank_q;
                        state_d = ST_AVG_LAUNCH;
                    end
                end else if (sub_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_AVG_LAUNCH: begin
                if (avg_accept)       state_d = ST_AVG_WAIT;
                else if (avg_timeout) state_d = ST_ERR;
            end
            ST_AVG_WAIT: begin
                if (avg_done)         state_d = ST_SWAP;
                else if (avg_timeout) state_d = ST_ERR;
            end
            ST_SWAP: begin
                bank_d  = ~bank_q;
                iter_d  = iter_q + ITER_W'(1);
                state_d = ((iter_q + ITER_W'(1)) == iters_q) ? ST_DONE : ST_SUB_LAUNCH;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_ERR) error_d = 1'b1;
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        sub_start_o    = sub_start;
        avg_start_o    = avg_start;
        busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
        done_o         = (state_q == ST_DONE);
        error_o        = error_q;
        vertex_count_o = vcount_q;
        face_count_o   = fcount_q;
        bank_sel_o     = bank_q;
        iter_cnt_o     = iter_q;
    end

endmodule

// File: tb/tb_subdiv_scheduler.sv
// Self-checking bench for subdiv_scheduler with behavioural subdivider and
// averager stubs that sample start on the falling clock edge.
module tb_subdiv_scheduler;

    localparam int ITER_W = 4;

    typedef struct {
        int iters;  int vc;     int fc;
        int subLen; int avgLen; int retV; int retF;
        int subNever; int avgNever; int midCmd;
        int expEnd; int expErr; int expVc; int expFc; int expIter; int expBank;
        int expSubL; int expAvgL; int expToggles;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_start = 1'b0;
    logic [ITER_W-1:0] cmd_iters = '0;
    logic [31:0]       vin = '0;
    logic [31:0]       fin = '0;
    logic              sub_start;
    logic              sub_busy = 1'b0;
    logic [31:0]       sub_v = '0;
    logic [31:0]       sub_f = '0;
    logic              avg_start;
    logic              avg_busy = 1'b0;
    logic [31:0]       vc, fc;
    logic              bank;
    logic [ITER_W-1:0] iter;
    logic              busy, done, err;

    int total = 0;
    int bad = 0;

    int subLen = 5, avgLen = 10, retV = 0, retF = 0, subNever = 0, avgNever = 0;
    int subCnt = 0, avgCnt = 0;

    int  subL = 0, avgL = 0, toggles = 0, doneCnt = 0, altBad = 0, overlapBad = 0, bankBad = 0;
    logic prevSub = 1'b0, prevAvg = 1'b0, prevBank = 1'b0;
    byte lastL = "A";

    subdiv_scheduler #(.ITER_W(ITER_W), .TIMEOUT_CYCLES(64), .ADDR_WIDTH(9)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_start_i       (cmd_start),
        .cmd_iters_i       (cmd_iters),
        .vertex_count_in_i (vin),
        .face_count_in_i   (fin),
        .sub_start_o       (sub_start),
        .sub_busy_i        (sub_busy),
        .sub_vertex_count_i(sub_v),
        .sub_face_count_i  (sub_f),
        .avg_start_o       (avg_start),
        .avg_busy_i        (avg_busy),
        .vertex_count_o    (vc),
        .face_count_o      (fc),
        .bank_sel_o        (bank),
        .iter_cnt_o        (iter),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Subdivider stub: results are garbage while busy and valid once busy falls.
    always @(negedge clk) begin
        if (sub_busy) begin
            subCnt = subCnt - 1;
            if (subCnt <= 0) begin
                sub_busy = 1'b0;
                sub_v    = 32'(retV);
                sub_f    = 32'(retF);
            end
        end else if (sub_start && subNever == 0) begin
            sub_busy = 1'b1;
            subCnt   = subLen;
            sub_v    = '1;
            sub_f    = '1;
        end
    end

    // Averager stub.
    always @(negedge clk) begin
        if (avg_busy) begin
            avgCnt = avgCnt - 1;
            if (avgCnt <= 0) avg_busy = 1'b0;
        end else if (avg_start && avgNever == 0) begin
            avg_busy = 1'b1;
            avgCnt   = avgLen;
        end
    end

    // Protocol monitor: launch counts, alternation, start overlap, bank changes, done pulses.
    always @(posedge clk) begin
        #1;
        if (sub_start && !prevSub) begin
            subL++;
            if (lastL == "S") altBad++;
            lastL = "S";
        end
        if (avg_start && !prevAvg) begin
            avgL++;
            if (lastL != "S") altBad++;
            lastL = "A";
        end
        if (!busy) lastL = "A";
        if (sub_start && avg_start) overlapBad++;
        if (bank != prevBank) begin
            toggles++;
            if (prevSub || prevAvg) bankBad++;
        end
        if (done) doneCnt++;
        prevSub  = sub_start;
        prevAvg  = avg_start;
        prevBank = bank;
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitStubsIdle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sub_busy && !avg_busy && !busy) break;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int endCyc, s0, a0, t0, d0, alt0, ov0, bb0;
        subLen   = v.subLen;  avgLen = v.avgLen;
        retV     = v.retV;    retF   = v.retF;
        subNever = v.subNever; avgNever = v.avgNever;
        @(negedge clk);
        s0 = subL; a0 = avgL; d0 = doneCnt; alt0 = altBad; ov0 = overlapBad; bb0 = bankBad;
        t0 = toggles;
        cmd_start = 1'b1;
        cmd_iters = 4'(v.iters);
        vin       = 32'(v.vc);
        fin       = 32'(v.fc);
        endCyc    = 0;
        for (int c = 1; c <= 300 && endCyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_start = 1'b0;
                t0 = toggles;
                checkOutput({tag, ".subStartLatency"}, sub_start, v.iters != 0);
                checkOutput({tag, ".errorClearedOnStart"}, err, 0);
                checkOutput({tag, ".busyAfterStart"}, busy, v.iters != 0);
            end
            if (v.midCmd != 0 && c == v.midCmd) begin
                cmd_start = 1'b1;
                cmd_iters = 4'd3;
                vin       = 32'd99;
                fin       = 32'd99;
            end
            if (v.midCmd != 0 && c == v.midCmd + 1) cmd_start = 1'b0;
            if (done || err) endCyc = c;
        end
        cmd_start = 1'b0;
        checkOutput({tag, ".endCycle"}, endCyc, v.expEnd);
        checkOutput({tag, ".error"}, err, v.expErr);
        checkOutput({tag, ".done"}, done, v.expErr == 0);
        checkOutput({tag, ".busyAtEnd"}, busy, 0);
        checkOutput({tag, ".vertexCount"}, vc, v.expVc);
        checkOutput({tag, ".faceCount"}, fc, v.expFc);
        checkOutput({tag, ".iterCnt"}, iter, v.expIter);
        if (v.expBank >= 0) checkOutput({tag, ".bankSel"}, bank, v.expBank);
        @(negedge clk);
        checkOutput({tag, ".donePulseWidth"}, done, 0);
        checkOutput({tag, ".errorSticky"}, err, v.expErr);
        checkOutput({tag, ".subLaunches"}, subL - s0, v.expSubL);
        checkOutput({tag, ".avgLaunches"}, avgL - a0, v.expAvgL);
        checkOutput({tag, ".bankToggles"}, toggles - t0, v.expToggles);
        checkOutput({tag, ".donePulses"}, doneCnt - d0, v.expErr == 0);
        checkOutput({tag, ".alternation"}, altBad - alt0, 0);
        checkOutput({tag, ".startOverlap"}, overlapBad - ov0, 0);
        checkOutput({tag, ".bankWhileStart"}, bankBad - bb0, 0);
        waitStubsIdle();
    endtask

    initial begin
        vec_t vecs[$];
        int   d0;

        // iters vc fc subLen avgLen retV retF subNever avgNever midCmd |
        // expEnd expErr expVc expFc expIter expBank expSubL expAvgL expToggles
        vecs.push_back('{0, 8, 12, 5, 10, 26, 48, 0, 0, 0,   1, 0,   8,  12, 0,  0, 0, 0, 0});
        vecs.push_back('{1, 8, 12, 5, 10, 26, 48, 0, 0, 0,  19, 0,  26,  48, 1,  0, 1, 1, 2});
        vecs.push_back('{2, 8, 12, 5, 10, 26, 48, 0, 0, 0,  37, 0,  26,  48, 2,  0, 2, 2, 4});
        vecs.push_back('{3, 8, 12, 2,  3, 100, 70, 0, 0, 0, 25, 0, 100,  70, 3,  0, 3, 3, 6});
        vecs.push_back('{2, 8, 12, 3, 10, 200, 200, 0, 0, 0, 5, 1, 200, 200, 0,  0, 1, 0, 0});
        vecs.push_back('{1, 8, 12, 4, 10, 100, 71, 0, 0, 0,  6, 1, 100,  71, 0,  0, 1, 0, 0});
        vecs.push_back('{1, 8, 12, 5, 10, 26, 48, 1, 0, 0,  65, 1,   8,  12, 0,  0, 1, 0, 0});
        vecs.push_back('{4, 8, 12, 1,  1, 10, 20, 0, 0, 0,  21, 0,  10,  20, 4,  0, 4, 4, 8});
        vecs.push_back('{1, 8, 12, 5, 10, 26, 48, 0, 0, 5,  19, 0,  26,  48, 1,  0, 1, 1, 2});
        vecs.push_back('{1, 8, 12, 5, 10, 26, 48, 0, 1, 0,  71, 1,  26,  48, 0,  1, 1, 1, 1});
        vecs.push_back('{2, 30, 40, 3, 10, 200, 200, 0, 0, 0, 5, 1, 200, 200, 0, -1, 1, 0, 0});

        $display("[TB] reset state");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.subStart", sub_start, 0);
        checkOutput("reset.avgStart", avg_start, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.error", err, 0);
        checkOutput("reset.bankSel", bank, 0);
        checkOutput("reset.iterCnt", iter, 0);
        checkOutput("reset.vertexCount", vc, 0);
        checkOutput("reset.faceCount", fc, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            $display("[TB] vector %0d iters=%0d", i, vecs[i].iters);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an averaging pass.
        $display("[TB] reset during AVG_WAIT");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        subLen = 5; avgLen = 10; retV = 26; retF = 48; subNever = 0; avgNever = 0;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_iters = 4'd1;
        vin       = 32'd8;
        fin       = 32'd12;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (11) @(negedge clk);
        checkOutput("midReset.preBank", bank, 1);
        checkOutput("midReset.preBusy", busy, 1);
        checkOutput("midReset.preAvgBusy", avg_busy, 1);
        checkOutput("midReset.preVertexCount", vc, 26);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset.subStart", sub_start, 0);
        checkOutput("midReset.avgStart", avg_start, 0);
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.done", done, 0);
        checkOutput("midReset.error", err, 0);
        checkOutput("midReset.bankSel", bank, 0);
        checkOutput("midReset.iterCnt", iter, 0);
        checkOutput("midReset.vertexCount", vc, 0);
        checkOutput("midReset.faceCount", fc, 0);
        rst = 1'b0;
        d0 = doneCnt;
        repeat (12) @(negedge clk);
        checkOutput("midReset.noLateDone", doneCnt - d0, 0);
        checkOutput("midReset.staysIdle", busy, 0);
        checkOutput("midReset.noRelaunch", avg_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
